// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit and its branch history table.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch request bus between the PC unit (master) and the instruction buffer (slave).
interface fetch_pc_unit_if;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        fetch_pred_taken;
  logic [31:0] fetch_pred_target;

  modport master (output fetch_pc, fetch_valid, fetch_pred_taken, fetch_pred_target,
                  input  fetch_ready);
  modport slave  (input  fetch_pc, fetch_valid, fetch_pred_taken, fetch_pred_target,
                  output fetch_ready);
endinterface

// File: rtl/branch_history_table.sv
// Tag-less 2-bit direction counters plus targets: combinational read, registered write.
module branch_history_table
  import fetch_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [1:0]                 rd_ctr,
  output logic [31:0]                rd_tgt,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic                       wr_taken,
  input  logic [31:0]                wr_tgt
);

  logic [ENTRIES-1:0][1:0]  ctr_q;
  logic [ENTRIES-1:0][31:0] tgt_q;

  // Read sees the pre-update entry when read and write collide.
  assign rd_ctr = ctr_q[rd_idx];
  assign rd_tgt = tgt_q[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctr_q <= {ENTRIES{WNT}};
      tgt_q <= '0;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
      if (wr_taken) tgt_q[wr_idx] <= wr_tgt;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC and redirect controller. Define BRANCH_PREDICTOR_EN to add the
// 2-bit predictor; otherwise the unit is static not-taken.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  fetch_pc_unit_if.master fif,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_branch_taken,
  input  logic [31:0]     ex_pc,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic            flush,
  output logic            halted,
  output logic [15:0]     mispredict_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic         act, mispredict;
  logic [31:0]  correct_pc, pred_next_pc;

`ifdef BRANCH_PREDICTOR_EN
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0] bht_ctr;

  branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pc_q[IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .rd_tgt   (pred_target),
    .wr_en    (ex_valid & ex_is_branch),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_branch_taken),
    .wr_tgt   (ex_target)
  );
  assign pred_taken = bht_ctr[1];
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  assign act          = ex_is_jump | (ex_is_branch & ex_branch_taken);
  assign correct_pc   = act ? ex_target : ex_pc + 32'(INSTR_BYTES);
  assign mispredict   = ex_valid & ((act != ex_pred_taken) |
                                    (act & ex_pred_taken & (ex_pred_target != ex_target)));
  assign pred_next_pc = pred_taken ? pred_target : pc_q + 32'(INSTR_BYTES);

  // Halt suppresses the redirect so a kernel end is never undone by a late flush.
  assign flush  = mispredict & (state_q == RUN) & !halt_req;
  assign halted = (state_q == HALT);

  assign fif.fetch_pc          = pc_q;
  assign fif.fetch_valid       = (state_q == RUN);
  assign fif.fetch_pred_taken  = pred_taken;
  assign fif.fetch_pred_target = pred_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req)                             state_d = HALT;
        else if (flush)                           pc_d    = correct_pc;
        else if (stall)                           pc_d    = pc_q;
        else if (fif.fetch_valid && fif.fetch_ready) pc_d = pred_next_pc;
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      mispredict_count <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (flush && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected fetch stream checked by a scoreboard monitor.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, halt_req, ex_valid, ex_is_branch, ex_is_jump, ex_branch_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        flush, halted;
  logic [15:0] mispredict_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fetch_pc_unit_if fif ();

  fetch_pc_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fif              (fif),
    .stall            (stall),
    .halt_req         (halt_req),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jump       (ex_is_jump),
    .ex_branch_taken  (ex_branch_taken),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .flush            (flush),
    .halted           (halted),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted fetch request must match the next expected address.
  always @(negedge clk) begin
    if (reset_n && fif.fetch_valid && fif.fetch_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fetch_stream: got %h expected nothing", fif.fetch_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fif.fetch_pc !== e) begin
          bad++;
          $display("FAIL fetch_stream: got %h expected %h", fif.fetch_pc, e);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_branch_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic ex_drive(input logic br, input logic jp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg);
    ex_valid = 1; ex_is_branch = br; ex_is_jump = jp; ex_branch_taken = tk;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin
    reset_n = 0; fif.fetch_ready = 1; stall = 0; halt_req = 0;
    clr_ex();
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_valid", 32'(fif.fetch_valid), 32'h0);
    chk("rst_pc", fif.fetch_pc, 32'h1000);
    chk("rst_pred_taken", 32'(fif.fetch_pred_taken), 32'h0);
    chk("rst_pred_target", fif.fetch_pred_target, 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", 32'(mispredict_count), 32'h0);

    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("boot_valid", 32'(fif.fetch_valid), 32'h0);
    chk("boot_pc", fif.fetch_pc, 32'h1000);
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    exp_q.push_back(32'h1008); exp_q.push_back(32'h100C);
    nxt(); nxt(); nxt(); nxt();               // fetching 0x100C

    ex_drive(1, 0, 1, 32'h1010, 32'h1100, 0, 32'h0);
    @(negedge clk); chk("br_flush", 32'(flush), 32'h1);
    nxt(); clr_ex();                          // 0x1100
    chk("count_1", 32'(mispredict_count), 32'h1);
    exp_q.push_back(32'h1100); stall = 1;
    nxt();                                    // stall held 0x1100
    exp_q.push_back(32'h1100);
    ex_drive(0, 1, 0, 32'h1200, 32'h2000, 0, 32'h0);
    @(negedge clk); chk("stall_flush", 32'(flush), 32'h1);
    nxt(); clr_ex(); stall = 0;               // 0x2000
    exp_q.push_back(32'h2000);
    ex_drive(0, 1, 0, 32'h1F00, 32'h3000, 1, 32'h3004);
    @(negedge clk); chk("tgt_flush", 32'(flush), 32'h1);
    nxt(); clr_ex();                          // 0x3000
    exp_q.push_back(32'h3000);
    ex_drive(1, 0, 0, 32'h2FF0, 32'h2800, 0, 32'h0);
    @(negedge clk); chk("nt_noflush", 32'(flush), 32'h0);
    nxt(); clr_ex(); fif.fetch_ready = 0;     // 0x3004, buffer not ready
    @(negedge clk); chk("notready_valid", 32'(fif.fetch_valid), 32'h1);
    nxt(); fif.fetch_ready = 1;               // still 0x3004
    exp_q.push_back(32'h3004);
    ex_drive(1, 0, 1, 32'h1010, 32'h1100, 1, 32'h1100);
    @(negedge clk); chk("correct_noflush", 32'(flush), 32'h0);
    nxt(); clr_ex();                          // 0x3008
    exp_q.push_back(32'h3008);
    ex_drive(0, 1, 0, 32'h3008, 32'h1010, 0, 32'h0);
    nxt(); clr_ex();                          // 0x1010
    exp_q.push_back(32'h1010);
    @(negedge clk);
`ifdef BRANCH_PREDICTOR_EN
    chk("pred_taken", 32'(fif.fetch_pred_taken), 32'h1);
    chk("pred_target", fif.fetch_pred_target, 32'h1100);
    nxt();
    exp_q.push_back(32'h1100);
`else
    chk("pred_taken", 32'(fif.fetch_pred_taken), 32'h0);
    nxt();
    exp_q.push_back(32'h1014);
`endif
    ex_drive(1, 0, 0, 32'h1010, 32'h1100, 1, 32'h1100);
    @(negedge clk); chk("nt_pred_flush", 32'(flush), 32'h1);
    nxt(); clr_ex();                          // 0x1014
    exp_q.push_back(32'h1014);
    chk("count_5", 32'(mispredict_count), 32'h5);
    ex_drive(0, 1, 0, 32'h1014, 32'hFFFF_FFFC, 0, 32'h0);
    nxt(); clr_ex();                          // 0xFFFFFFFC
    exp_q.push_back(32'hFFFF_FFFC);
    nxt();                                    // wrapped to 0
    exp_q.push_back(32'h0);
    halt_req = 1;
    ex_drive(0, 1, 0, 32'h0, 32'h5000, 0, 32'h0);
    @(negedge clk); chk("halt_noflush", 32'(flush), 32'h0);
    nxt(); clr_ex(); halt_req = 0;
    @(negedge clk);
    chk("halted", 32'(halted), 32'h1);
    chk("halt_valid", 32'(fif.fetch_valid), 32'h0);
    chk("halt_count", 32'(mispredict_count), 32'h6);
    chk("halt_pc", fif.fetch_pc, 32'h0);

    #1 reset_n = 0;
    #1;
    chk("async_pc", fif.fetch_pc, 32'h1000);
    chk("async_halted", 32'(halted), 32'h0);
    chk("async_count", 32'(mispredict_count), 32'h0);

    @(posedge clk); #1 reset_n = 1; fif.fetch_ready = 0;
    ex_drive(0, 1, 0, 32'h0, 32'h8000, 0, 32'h0);
    nxt();                                    // RUN, flushing every cycle
    repeat (65535) nxt();
    chk("sat_count", 32'(mispredict_count), 32'hFFFF);
    chk("sat_flush", 32'(flush), 32'h1);
    nxt();
    chk("sat_hold", 32'(mispredict_count), 32'hFFFF);
    clr_ex();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and redirect controller for the matmul core's fetch stage. It consumes the execute-stage branch resolution (the taken/not-taken outcome from the branch comparator, plus jump and target information) and produces the next fetch address, a one-cycle pipeline flush on misprediction, and a fetch request handshake toward the instruction buffer. An optional 2-bit direction predictor with a tag-less target table provides speculative redirects.

## Interface
- `RESET_PC`, default `32'h0000_1000`: fetch address after reset.
- `BHT_ENTRIES`, default `16`: predictor entries, power of two; index is `pc[log2(BHT_ENTRIES)+1:2]`.
- `clk`  in  1  core clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_pc`  out  32  current fetch address.
- `fetch_valid`  out  1  fetch request valid.
- `fetch_ready`  in  1  instruction buffer accepts the request.
- `fetch_pred_taken`  out  1  prediction for `fetch_pc`, carried down the pipeline.
- `fetch_pred_target`  out  32  predicted target for `fetch_pc`, carried down the pipeline.
- `stall`  in  1  hazard stall; hold `fetch_pc`.
- `halt_req`  in  1  end-of-kernel request; stop fetching.
- `ex_valid`  in  1  a control-flow instruction resolves in EX this cycle.
- `ex_is_branch`, `ex_is_jump`  in  1 each  instruction class; mutually exclusive.
- `ex_branch_taken`  in  1  comparator outcome.
- `ex_pc`, `ex_target`  in  32 each  instruction address and resolved target.
- `ex_pred_taken`, `ex_pred_target`  in  1 / 32  prediction carried from fetch.
- `flush`  out  1  kill IF/ID contents this cycle.
- `halted`  out  1  unit is in HALT.
- `mispredict_count`  out  16  saturating misprediction counter.

## Operation
- FSM states: BOOT, RUN, HALT. On reset the FSM enters BOOT. BOOT always moves to RUN after one cycle. In RUN, `halt_req` moves the FSM to HALT. HALT is left only by reset.
- Reset values: `fetch_pc`=`RESET_PC`, `fetch_valid`=0, `fetch_pred_taken`=0, `fetch_pred_target`=0, `flush`=0, `halted`=0, `mispredict_count`=0. Predictor counters reset to 2'b01 (weakly not-taken) and targets to 0.
- `fetch_valid`=1 only in RUN. `halted`=1 only in HALT.
- Resolved taken: `act` = `ex_is_jump` | (`ex_is_branch` & `ex_branch_taken`). Correct PC = `act` ? `ex_target` : `ex_pc`+4. Addition is modulo 2^32 and wraps.
- A misprediction is any case where `ex_valid` & (`act`≠`ex_pred_taken` | (`act` & `ex_pred_taken` & `ex_pred_target`≠`ex_target`)) holds.
- `flush` is combinational. It equals misprediction & state==RUN & !`halt_req`.
- Next-PC priority in RUN, highest first:
  1. `halt_req`: hold.
  2. `flush`: correct PC.
  3. `stall`: hold.
  4. Handshake (`fetch_valid` & `fetch_ready`): predicted next PC.
  5. Otherwise: hold.
- Predicted next PC = `fetch_pred_taken` ? `fetch_pred_target` : `fetch_pc`+4.
- `mispredict_count` increments on every `flush` and saturates at 16'hFFFF.
- `fetch_pc` is stable while `fetch_valid` & !`fetch_ready`. The only exception is `flush`, which may change it.

## Timing
- Redirect penalty: a misprediction presented in cycle N asserts `flush` in N. The correct PC appears on `fetch_pc` in N+1 with `fetch_valid`=1.
- Predictor lookup is combinational on `fetch_pc`. Predictor update is registered at the edge ending the `ex_valid` cycle.
- If an update and a lookup hit the same index in the same cycle, the lookup sees the old entry.
- A mispredict and a `stall` in the same cycle: the redirect wins. A mispredict and a `halt_req` in the same cycle: the halt wins, and there is no flush or counter increment.
- Reset assertion mid-operation immediately forces all reset values, independent of `clk`.

## Configuration
- `BRANCH_PREDICTOR_EN` defined:
  - Predictor table instantiated.
  - On `ex_valid` & `ex_is_branch`, the counter at the `ex_pc` index increments if taken and decrements if not, saturating at 0 and 3.
  - On a taken branch, `ex_target` is written to the entry's target.
  - `fetch_pred_taken` = counter[1]. `fetch_pred_target` = stored target.
  - Jumps never update the table.
- `BRANCH_PREDICTOR_EN` undefined:
  - No table.
  - `fetch_pred_taken`=0 and `fetch_pred_target`=0 constantly; the unit is static not-taken.
  - Every taken branch or jump flushes.

## Structure
- Shared package `fetch_pkg` holds:
  - The FSM state enum.
  - `INSTR_BYTES`=4.
  - The 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3).
  - `RESET_PC_DEFAULT`.
- Sub-module `branch_history_table` holds the counters and targets: one combinational read port and one registered write port. It is instantiated only under `BRANCH_PREDICTOR_EN`.

## Test plan
- Reset release with `fetch_ready`=1 → cycle 1: `fetch_valid`=0, `fetch_pc`=0x1000. Then 0x1000, 0x1004, 0x1008 on consecutive cycles.
- Branch at `ex_pc`=0x1010, taken, `ex_target`=0x1100, `ex_pred_taken`=0 → `flush`=1 that cycle, next `fetch_pc`=0x1100, `mispredict_count`=1.
- `stall`=1 and a mispredict in the same cycle → redirect taken, `fetch_pc`=target next cycle. `stall` alone holds `fetch_pc` unchanged.
- `halt_req` together with a mispredict → `flush`=0, `halted`=1 next cycle, `fetch_valid`=0, counter unchanged.
- `BRANCH_PREDICTOR_EN`: two taken resolutions of the branch at 0x1010 → target 0x1100. Next fetch of 0x1010 → `fetch_pred_taken`=1 and the following `fetch_pc`=0x1100. A not-taken resolution with pred=1 → flush to 0x1014.
- Force 0xFFFF mispredicts, then one more → `mispredict_count` stays 0xFFFF. `fetch_pc`=0xFFFF_FFFC advancing → 0x0000_0000.
